mc_control_unit: RTL and testbench

- Parametrised next-generation multicycle ARM-subset controller: main FSM, instruction decode and conditional-execution logic in one block.
- Adds three things: a memory ready handshake that stalls the FSM, a multi-cycle multiply path with a programmable latency, and a configurable ALUControl width.
- Sits between the instruction register/ALU flags and the multicycle datapath, and drives every datapath enable and mux select.

---
 rtl/mc_control_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle ARM-subset controller: FSM, decode, conditional execution
module mc_control_unit #(
    parameter int ALUCTRL_W    = 4,
    parameter int MUL_CYCLES   = 4,
    parameter bit COND_NV_EXEC = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 MulStart,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_MULWAIT = 4'd10
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(4);
    localparam logic [3:0]           MUL_LAST = 4'(MUL_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_flags;
    logic [3:0] r_mul_cnt;

    logic [1:0]           w_op;
    logic [5:0]           w_funct;
    logic [3:0]           w_cmd;
    logic                 w_is_mul;
    logic                 w_is_cmp;
    logic                 w_cond_ex;
    logic                 w_reg_we;
    logic [ALUCTRL_W-1:0] w_alu_dp;
    logic                 w_unused;

    assign w_op     = Instr[27:26];
    assign w_funct  = Instr[25:20];
    assign w_cmd    = Instr[24:21];
    assign w_is_mul = (w_op == 2'b00) && !w_funct[5] && (w_cmd == 4'b0000) && (Instr[7:4] == 4'b1001);
    assign w_is_cmp = (w_cmd == 4'b1010);
    assign w_unused = ^{Instr[19:16], Instr[11:8], Instr[3:0]};
    assign State    = r_state;

    // Flags are {N, Z, C, V}
    always_comb begin
        w_cond_ex = 1'b0;
        case (Instr[31:28])
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = !r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = !r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = !r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = !r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] && !r_flags[2];
            4'b1001: w_cond_ex = !r_flags[1] || r_flags[2];
            4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ex = !r_flags[2] && (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ex = r_flags[2] || (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = COND_NV_EXEC;
        endcase
    end

    always_comb begin
        w_alu_dp = ALU_ADD;
        case (w_cmd)
            4'b0010, 4'b1010: w_alu_dp = ALU_SUB;
            4'b0000:          w_alu_dp = ALU_AND;
            4'b1100:          w_alu_dp = ALU_ORR;
            4'b0001:          w_alu_dp = ALU_EOR;
            default:          w_alu_dp = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_flags   <= 4'b0000;
            r_mul_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_FETCH:  if (MemReady) r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_op)
                        2'b01:   r_state <= S_MEMADR;
                        2'b10:   r_state <= S_BRANCH;
                        2'b00:   r_state <= w_funct[5] ? S_EXECI : S_EXECR;
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= w_funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (MemReady) r_state <= S_MEMWB;
                S_MEMWR:  if (MemReady) r_state <= S_FETCH;
                S_MEMWB:  r_state <= S_FETCH;
                S_EXECR: begin
                    if (w_is_mul) begin
                        r_state   <= S_MULWAIT;
                        r_mul_cnt <= 4'd0;
                    end else begin
                        r_state <= S_ALUWB;
                        if (w_cond_ex && (w_funct[0] || w_is_cmp))
                            r_flags <= ALUFlags;
                    end
                end
                S_EXECI: begin
                    r_state <= S_ALUWB;
                    if (w_cond_ex && (w_funct[0] || w_is_cmp))
                        r_flags <= ALUFlags;
                end
                // Multiply updates only N and Z; C and V keep their old values
                S_MULWAIT: begin
                    if (r_mul_cnt == MUL_LAST) begin
                        r_state <= S_ALUWB;
                        if (w_cond_ex && w_funct[0])
                            r_flags[3:2] <= ALUFlags[3:2];
                    end else begin
                        r_mul_cnt <= r_mul_cnt + 4'd1;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = Instr[27:26];
        ALUControl = ALU_ADD;
        MulStart   = 1'b0;
        w_reg_we   = w_cond_ex && (w_is_mul || !w_is_cmp);
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = {(w_op == 2'b01) && !w_funct[0], (w_op == 2'b10)};
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: AdrSrc = 1'b1;
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = MemReady && w_cond_ex;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = w_cond_ex;
            end
            S_EXECR: begin
                ALUControl = w_alu_dp;
                MulStart   = w_is_mul;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_dp;
            end
            S_ALUWB: begin
                ResultSrc = w_is_mul ? 2'b11 : 2'b00;
                RegWrite  = w_reg_we;
                PCWrite   = w_reg_we && (Instr[15:12] == 4'hF);
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = w_cond_ex;
            end
            default: ;
        endcase
        if (!reset) begin
            PCWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            IRWrite    = 1'b0;
            AdrSrc     = 1'b0;
            RegSrc     = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ResultSrc  = 2'b00;
            ImmSrc     = 2'b00;
            ALUControl = ALU_ADD;
            MulStart   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed-vector bench for mc_control_unit
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, MulStart;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [3:0]  ALUControl;
    logic [3:0]  State;
    logic [19:0] outs;

    int vecs = 0;
    int errs = 0;

    mc_control_unit dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .MulStart(MulStart), .State(State)
    );

    assign outs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                   ALUSrcB, ResultSrc, ImmSrc, ALUControl, MulStart};

    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge, outputs are sampled 1 unit later
    task automatic step(input logic ready);
        @(posedge clk);
        #2;
        MemReady = ready;
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins);
        Instr    = ins;
        MemReady = 1'b1;
        step(1'b0);
    endtask

    task automatic test_reset;
        vecs++; if (State !== 4'd0) begin errs++; $display("FAIL reset_state got %0d want 0", State); end
        vecs++; if (outs !== 20'd0) begin errs++; $display("FAIL reset_outs got %h want 00000", outs); end
        reset = 1'b1;
        step(1'b0);
        vecs++; if (State !== 4'd0 || IRWrite !== 1'b0) begin errs++; $display("FAIL post_reset state=%0d irw=%b want 0/0", State, IRWrite); end
        fetch(32'h0A00_0000);
        step(1'b0);
        vecs++; if (State !== 4'd9) begin errs++; $display("FAIL beq0_state got %0d want 9", State); end
        vecs++; if (PCWrite !== 1'b0) begin errs++; $display("FAIL beq0_pcwrite got %b want 0", PCWrite); end
        step(1'b0);
        vecs++; if (State !== 4'd0) begin errs++; $display("FAIL beq0_ret got %0d want 0", State); end
    endtask

    task automatic test_fetch_stall;
        Instr = 32'hEC00_0000;
        for (int i = 0; i < 3; i++) begin
            vecs++; if (State !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0)
                begin errs++; $display("FAIL stall_%0d state=%0d irw=%b pcw=%b want 0/0/0", i, State, IRWrite, PCWrite); end
            step(i == 2);
        end
        vecs++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin errs++; $display("FAIL fetch_en irw=%b pcw=%b want 1/1", IRWrite, PCWrite); end
        vecs++; if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} !== 11'b0_01_10_10_0000)
            begin errs++; $display("FAIL fetch_sel got %b want 00110100000", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}); end
        step(1'b0);
        vecs++; if (State !== 4'd1 || IRWrite !== 1'b0) begin errs++; $display("FAIL fetch_dec state=%0d irw=%b want 1/0", State, IRWrite); end
        step(1'b0);
        vecs++; if (State !== 4'd0) begin errs++; $display("FAIL undef_nop got %0d want 0", State); end
    endtask

    task automatic test_subs_beq;
        fetch(32'hE251_1001);
        vecs++; if (State !== 4'd1 || RegSrc !== 2'b00) begin errs++; $display("FAIL subs_dec state=%0d regsrc=%b want 1/00", State, RegSrc); end
        ALUFlags = 4'b0100;
        step(1'b0);
        vecs++; if (State !== 4'd7 || ALUSrcB !== 2'b01 || ALUControl !== 4'd1)
            begin errs++; $display("FAIL subs_exec state=%0d srcb=%b alu=%0d want 7/01/1", State, ALUSrcB, ALUControl); end
        step(1'b0);
        ALUFlags = 4'b0000;
        vecs++; if (State !== 4'd8 || RegWrite !== 1'b1 || ResultSrc !== 2'b00 || PCWrite !== 1'b0)
            begin errs++; $display("FAIL subs_wb state=%0d rw=%b rs=%b pcw=%b want 8/1/00/0", State, RegWrite, ResultSrc, PCWrite); end
        step(1'b0);
        fetch(32'h0A00_0000);
        vecs++; if (RegSrc !== 2'b01) begin errs++; $display("FAIL beq_regsrc got %b want 01", RegSrc); end
        step(1'b0);
        vecs++; if (PCWrite !== 1'b1 || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01)
            begin errs++; $display("FAIL beq_taken pcw=%b srca=%b srcb=%b want 1/10/01", PCWrite, ALUSrcA, ALUSrcB); end
        step(1'b0);
        vecs++; if (State !== 4'd0) begin errs++; $display("FAIL beq_ret got %0d want 0", State); end
    endtask

    task automatic test_bne;
        fetch(32'h1A00_0000);
        step(1'b0);
        vecs++; if (State !== 4'd9 || PCWrite !== 1'b0) begin errs++; $display("FAIL bne state=%0d pcw=%b want 9/0", State, PCWrite); end
        step(1'b0);
        vecs++; if (State !== 4'd0) begin errs++; $display("FAIL bne_ret got %0d want 0", State); end
    endtask

    task automatic test_mul;
        fetch(32'hE000_0291);
        step(1'b0);
        vecs++; if (State !== 4'd6 || MulStart !== 1'b1 || ALUSrcB !== 2'b00)
            begin errs++; $display("FAIL mul_exec state=%0d ms=%b srcb=%b want 6/1/00", State, MulStart, ALUSrcB); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            vecs++; if (State !== 4'd10 || MulStart !== 1'b0)
                begin errs++; $display("FAIL mulwait_%0d state=%0d ms=%b want 10/0", i, State, MulStart); end
        end
        step(1'b0);
        vecs++; if (State !== 4'd8 || ResultSrc !== 2'b11 || RegWrite !== 1'b1 || MulStart !== 1'b0)
            begin errs++; $display("FAIL mul_wb state=%0d rs=%b rw=%b ms=%b want 8/11/1/0", State, ResultSrc, RegWrite, MulStart); end
        step(1'b0);
    endtask

    task automatic test_mem;
        fetch(32'hE510_1004);
        step(1'b0);
        vecs++; if (State !== 4'd2 || ALUControl !== 4'd1 || ALUSrcB !== 2'b01)
            begin errs++; $display("FAIL ldr_adr state=%0d alu=%0d srcb=%b want 2/1/01", State, ALUControl, ALUSrcB); end
        for (int i = 0; i < 3; i++) begin
            step(i == 2);
            vecs++; if (State !== 4'd3 || AdrSrc !== 1'b1)
                begin errs++; $display("FAIL ldr_rd_%0d state=%0d adr=%b want 3/1", i, State, AdrSrc); end
        end
        step(1'b0);
        vecs++; if (State !== 4'd4 || ResultSrc !== 2'b01 || RegWrite !== 1'b1)
            begin errs++; $display("FAIL ldr_wb state=%0d rs=%b rw=%b want 4/01/1", State, ResultSrc, RegWrite); end
        step(1'b0);
        fetch(32'hE580_1004);
        vecs++; if (RegSrc !== 2'b10) begin errs++; $display("FAIL str_regsrc got %b want 10", RegSrc); end
        step(1'b0);
        vecs++; if (ALUControl !== 4'd0) begin errs++; $display("FAIL str_adr alu=%0d want 0", ALUControl); end
        step(1'b1);
        vecs++; if (State !== 4'd5 || MemWrite !== 1'b1) begin errs++; $display("FAIL str_wr state=%0d mw=%b want 5/1", State, MemWrite); end
        step(1'b0);
        vecs++; if (State !== 4'd0) begin errs++; $display("FAIL str_ret got %0d want 0", State); end
        fetch(32'hF510_1004);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        vecs++; if (State !== 4'd4 || RegWrite !== 1'b0) begin errs++; $display("FAIL nv_ldr state=%0d rw=%b want 4/0", State, RegWrite); end
        step(1'b0);
    endtask

    task automatic test_alu_pc_cmp;
        fetch(32'hE080_F001);
        step(1'b0);
        vecs++; if (State !== 4'd6 || ALUControl !== 4'd0) begin errs++; $display("FAIL addpc_exec state=%0d alu=%0d want 6/0", State, ALUControl); end
        step(1'b0);
        vecs++; if (RegWrite !== 1'b1 || PCWrite !== 1'b1) begin errs++; $display("FAIL addpc_wb rw=%b pcw=%b want 1/1", RegWrite, PCWrite); end
        step(1'b0);
        fetch(32'hE351_0000);
        ALUFlags = 4'b0010;
        step(1'b0);
        vecs++; if (State !== 4'd7 || ALUControl !== 4'd1) begin errs++; $display("FAIL cmp_exec state=%0d alu=%0d want 7/1", State, ALUControl); end
        step(1'b0);
        ALUFlags = 4'b0000;
        vecs++; if (RegWrite !== 1'b0 || PCWrite !== 1'b0) begin errs++; $display("FAIL cmp_wb rw=%b pcw=%b want 0/0", RegWrite, PCWrite); end
        step(1'b0);
        fetch(32'h0A00_0000);
        step(1'b0);
        vecs++; if (PCWrite !== 1'b0) begin errs++; $display("FAIL cmp_beq pcw=%b want 0", PCWrite); end
        step(1'b0);
        fetch(32'h2A00_0000);
        step(1'b0);
        vecs++; if (PCWrite !== 1'b1) begin errs++; $display("FAIL cmp_bcs pcw=%b want 1", PCWrite); end
        step(1'b0);
    endtask

    task automatic test_reset_midmul;
        fetch(32'hE000_0291);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        vecs++; if (State !== 4'd10) begin errs++; $display("FAIL premid_state got %0d want 10", State); end
        reset = 1'b0;
        #1;
        vecs++; if (State !== 4'd0 || outs !== 20'd0) begin errs++; $display("FAIL midreset state=%0d outs=%h want 0/00000", State, outs); end
        step(1'b0);
        reset = 1'b1;
        step(1'b0);
        vecs++; if (State !== 4'd0) begin errs++; $display("FAIL midrel_state got %0d want 0", State); end
        fetch(32'h2A00_0000);
        vecs++; if (State !== 4'd1) begin errs++; $display("FAIL midrel_fetch got %0d want 1", State); end
        step(1'b0);
        vecs++; if (State !== 4'd9 || PCWrite !== 1'b0) begin errs++; $display("FAIL midrel_bcs state=%0d pcw=%b want 9/0", State, PCWrite); end
        step(1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        Instr    = 32'hE590_0000;
        ALUFlags = 4'b0000;
        MemReady = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        test_reset();
        test_fetch_stall();
        test_subs_beq();
        test_bne();
        test_mul();
        test_mem();
        test_alu_pc_cmp();
        test_reset_midmul();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
